// File: rtl/pattern_player.sv
// Pattern player: walks a circular range of pattern buffers, latches each selected buffer
// into shadow registers and streams its bytes over a valid/ready interface.
module pattern_player #(
   parameter int unsigned buffer_size  = 22,
   parameter int unsigned buffer_width = 8,
   parameter int unsigned no_bufs      = 8
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                start,
   input  logic                                stop,
   input  logic [2:0]                          first_buf,
   input  logic [2:0]                          last_buf,
   input  logic [7:0]                          loops,
   input  logic [buffer_size*buffer_width-1:0] current_buffer,
   output logic [no_bufs-1:0]                  buffer_select,
   output logic [buffer_width-1:0]             pat_out,
   output logic                                pat_valid,
   input  logic                                pat_ready,
   output logic [4:0]                          byte_idx,
   output logic                                busy,
   output logic                                done
);

   localparam logic [4:0] LastByte = 5'(buffer_size - 1);
   localparam logic [2:0] LastBuf  = 3'(no_bufs - 1);

   typedef enum logic [1:0] {StIdle, StSelect, StLoad, StPlay} state_e;

   state_e                            r_state;
   state_e                            w_state_next;
   logic [buffer_size*buffer_width-1:0] r_shadow;
   logic [4:0]                        r_byte_idx;
   logic [2:0]                        r_buf_idx;
   logic [2:0]                        r_first_buf;
   logic [2:0]                        r_last_buf;
   logic [7:0]                        r_loop;
   logic                              r_stop_pend;
   logic                              r_done;

   logic       w_xfer;
   logic       w_stop_req;
   logic       w_last_byte;
   logic       w_last_buf;
   logic       w_last_pass;
   logic [2:0] w_buf_inc;

   // In PLAY the beat is always valid, so a transfer is simply ready while playing.
   assign w_xfer      = (r_state == StPlay) && pat_ready;
   assign w_stop_req  = stop || r_stop_pend;
   assign w_last_byte = (r_byte_idx == LastByte);
   assign w_last_buf  = (r_buf_idx == r_last_buf);
   assign w_last_pass = (r_loop == 8'd1);
   assign w_buf_inc   = (r_buf_idx == LastBuf) ? 3'd0 : r_buf_idx + 3'd1;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state decode
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         StIdle: begin
            if (start && !stop) w_state_next = StSelect;
         end
         StSelect: begin
            w_state_next = stop ? StIdle : StLoad;
         end
         StLoad: begin
            w_state_next = stop ? StIdle : StPlay;
         end
         StPlay: begin
            // A stalled beat defers any stop until it has been accepted.
            if (w_xfer) begin
               if (w_stop_req) begin
                  w_state_next = StIdle;
               end else if (w_last_byte) begin
                  w_state_next = (w_last_buf && w_last_pass) ? StIdle : StSelect;
               end
            end
         end
         default: w_state_next = StIdle;
      endcase
   end

   // Outputs decoded from state and datapath registers
   always_comb begin
      busy          = (r_state != StIdle);
      pat_valid     = (r_state == StPlay);
      byte_idx      = r_byte_idx;
      done          = r_done;
      pat_out       = r_shadow[r_byte_idx*buffer_width +: buffer_width];
      buffer_select = '0;
      buffer_select[r_buf_idx] = 1'b1;
   end

   // Datapath: range/loop bookkeeping, shadow capture, byte stepping, done and stop latch
   always_ff @(posedge clk) begin
      if (rst) begin
         r_shadow    <= '0;
         r_byte_idx  <= '0;
         r_buf_idx   <= '0;
         r_first_buf <= '0;
         r_last_buf  <= '0;
         r_loop      <= '0;
         r_stop_pend <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_done      <= (r_state != StIdle) && (w_state_next == StIdle);
         r_stop_pend <= (r_state == StPlay) && !w_xfer && w_stop_req;
         case (r_state)
            StIdle: begin
               if (w_state_next == StSelect) begin
                  r_buf_idx   <= first_buf;
                  r_first_buf <= first_buf;
                  r_last_buf  <= last_buf;
                  r_loop      <= loops;
               end
            end
            StLoad: begin
               if (w_state_next == StPlay) begin
                  r_shadow   <= current_buffer;
                  r_byte_idx <= '0;
               end
            end
            StPlay: begin
               if (w_xfer) begin
                  if (w_state_next == StSelect) begin
                     r_buf_idx <= w_last_buf ? r_first_buf : w_buf_inc;
                     // A zero count means endless playback, so it never decrements.
                     if (w_last_buf && (r_loop != 8'd0)) r_loop <= r_loop - 8'd1;
                  end else if (w_state_next == StPlay) begin
                     r_byte_idx <= r_byte_idx + 5'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/pattern_player.md
PATTERN_PLAYER -- requirements
Module: pattern_player

Interface
REQ-001 Parameters SHALL be: buffer_size, default 22, bytes per pattern buffer; buffer_width, default 8, bits per byte; no_bufs, default 8, number of pattern buffers.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  one-cycle request to begin playback; it SHALL be ignored while busy.
REQ-005 stop  input  1  request to abort playback.
REQ-006 first_buf  input  3  index of the first buffer in the play range.
REQ-007 last_buf  input  3  index of the last buffer in the play range.
REQ-008 loops  input  8  number of passes over the range; 0 means repeat until stop.
REQ-009 current_buffer  input  buffer_size*buffer_width  the selected buffer, flattened, with byte n at bits [n*buffer_width +: buffer_width].
REQ-010 buffer_select  output  no_bufs  one-hot select that drives the buffer bank.
REQ-011 pat_out  output  buffer_width  the pattern byte being presented.
REQ-012 pat_valid  output  1  pat_out holds a valid byte.
REQ-013 pat_ready  input  1  the downstream accepts the byte; a beat transfers on a cycle where pat_valid and pat_ready are both high.
REQ-014 byte_idx  output  5  index of the byte currently on pat_out.
REQ-015 busy  output  1  playback is in progress.
REQ-016 done  output  1  one-cycle pulse when playback ends.

Function
REQ-017 The FSM SHALL have four states: IDLE, SELECT, LOAD and PLAY.
REQ-018 From IDLE, on start && !stop, the block SHALL set buffer_select = onehot(first_buf), load the loop counter from loops, set busy, and go to SELECT.
REQ-019 SELECT SHALL last exactly one cycle so the bank mux can settle, then go to LOAD.
REQ-020 In LOAD, the block SHALL capture current_buffer into shadow registers, drive pat_out = shadow byte 0, set byte_idx = 0 and pat_valid = 1, and go to PLAY.
REQ-021 Start latency: pat_valid SHALL first be high in the third cycle after the cycle in which start is sampled.
REQ-022 In PLAY, on each transfer, the block SHALL present the next shadow byte with byte_idx+1 on the next cycle and keep pat_valid high with no bubble.
REQ-023 While pat_valid && !pat_ready, pat_out and byte_idx SHALL hold stable, and pat_valid SHALL NOT drop.
REQ-024 Changes on current_buffer after LOAD SHALL NOT affect pat_out, because output comes from the shadow registers.
REQ-025 On transfer of byte buffer_size-1 when the buffer is not last_buf, the block SHALL set buffer_select to the next index (7 wraps to 0), clear pat_valid, and go to SELECT, giving a 2-cycle pat_valid gap.
REQ-026 The range SHALL wrap modulo no_bufs, so first_buf > last_buf is legal; for example 6..1 plays 6, 7, 0, 1.
REQ-027 When first_buf == last_buf, the range SHALL be a single buffer.
REQ-028 On transfer of the last byte of last_buf: if the loop counter is 1, the block SHALL go to IDLE and pulse done.
REQ-029 Otherwise, the block SHALL decrement the counter (unless loops was 0), reload onehot(first_buf), and go to SELECT.
REQ-030 first_buf, last_buf and loops SHALL be sampled only at start.
REQ-031 buffer_select SHALL always be exactly one-hot, and SHALL hold its last value when idle.
REQ-032 Stop in SELECT or LOAD, or in PLAY with no pending beat (pat_valid && !pat_ready false), SHALL cause the next cycle to be IDLE with pat_valid = 0, busy = 0 and done = 1.
REQ-033 Stop in PLAY while a beat is stalled SHALL be latched; the block SHALL end as in REQ-032 on the cycle after that beat transfers.
REQ-034 If start and stop are both high in IDLE, the block SHALL take no action.
REQ-035 Internally, byte_idx SHALL be 5 bits, the loop counter 8 bits, and the buffer index 3 bits, all modulo arithmetic.

Reset
REQ-036 When rst is high at a clock edge, the block SHALL force IDLE, buffer_select = 1 (buffer 0), pat_out = 0, pat_valid = 0, byte_idx = 0, busy = 0, done = 0, loop counter = 0, and clear any pending stop.
REQ-037 rst SHALL take priority over start, stop and transfers, including when asserted mid-PLAY with a stalled beat, which is discarded.

Verification
REQ-038 Reset: assert rst for 2 cycles -> buffer_select=0x01, pat_valid=0, busy=0, done=0.
REQ-039 Single buffer: first=last=2, loops=1, pat_ready=1, buffer 2 holding bytes 0x00..0x15 -> buffer_select=0x04, pat_out 0x00..0x15 over 22 consecutive cycles starting 3 cycles after start, then done pulses once and busy drops.
REQ-040 Wrapped range: first=6, last=1, loops=2 -> buffer_select sequence 0x40, 0x80, 0x01, 0x02, 0x40, 0x80, 0x01, 0x02, 176 bytes delivered, a 2-cycle pat_valid gap at each buffer switch, and one done pulse.
REQ-041 Backpressure and shadowing: pat_ready random at 50%, current_buffer changed during PLAY -> pat_out and byte_idx stable while stalled, and the delivered sequence matches the contents captured at LOAD.
REQ-042 Stop: stop asserted at byte 5 while pat_ready=0, then pat_ready raised 3 cycles later -> byte 5 transfers, the next cycle has pat_valid=0 and done=1, and there is no byte 6.
REQ-043 Reset mid-play: loops=0 playback with rst asserted at byte 10 -> the next cycle shows reset values, and a following start replays from byte 0 of first_buf.
